// File: rtl/fht_stream_ctrl.sv
// Frame sequencer around fht_top: loads N = 4*2^A_BIT samples into the core,
// starts it, waits for completion and streams the N result bins back out.
module fht_stream_ctrl #(
  parameter int D_BIT  = 16,
  parameter int A_BIT  = 8,
  parameter int RD_LAT = 1
) (
  input  logic                 iCLK,
  input  logic                 iRESET,
  input  logic                 iEN,
  input  logic [D_BIT-2:0]     iS_DATA,
  input  logic                 iS_VALID,
  output logic                 oS_READY,
  output logic [D_BIT-2:0]     oCORE_DATA,
  output logic [A_BIT-1:0]     oCORE_ADDR_WR,
  output logic [3:0]           oCORE_WE,
  output logic                 oCORE_START,
  input  logic                 iCORE_RDY,
  output logic [4*A_BIT-1:0]   oCORE_ADDR_RD,
  input  logic [4*D_BIT-1:0]   iCORE_DATA,
  output logic [D_BIT-1:0]     oM_DATA,
  output logic                 oM_VALID,
  input  logic                 iM_READY,
  output logic                 oM_LAST,
  output logic                 oBUSY
);

  localparam int N  = 4 << A_BIT;
  localparam int CW = A_BIT + 2;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_UNLOAD} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   ld_cnt;
  logic [CW-1:0]   rd_cnt;
  logic            rd_done;
  logic            rdy_low_seen;

  logic [RD_LAT-1:0] pipe_vld;
  logic [1:0]        pipe_lane [RD_LAT];
  logic              pipe_last [RD_LAT];

  logic [D_BIT-1:0]  fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        fifo_cnt;

  logic              handshake_in, rd_issue, push, pop;
  logic [2:0]        inflight;
  logic [D_BIT-1:0]  push_data;

  assign oS_READY      = (state == S_LOAD);
  assign oCORE_START   = (state == S_START);
  assign oBUSY         = (state != S_IDLE);
  assign oCORE_ADDR_RD = {4{rd_cnt[CW-1:2]}};
  assign oM_VALID      = (fifo_cnt != 2'd0);
  assign oM_DATA       = fifo_data[rd_ptr];
  assign oM_LAST       = oM_VALID & fifo_last[rd_ptr];

  assign handshake_in = iS_VALID & oS_READY;
  assign pop          = oM_VALID & iM_READY;
  assign push         = pipe_vld[RD_LAT-1];
  assign push_data    = iCORE_DATA[int'(pipe_lane[RD_LAT-1])*D_BIT +: D_BIT];

  // A slot freed by this cycle's pop may be reused, which keeps one bin per cycle at RD_LAT = 1.
  always_comb begin
    inflight = 3'd0;
    for (int k = 0; k < RD_LAT; k++) inflight = inflight + 3'(pipe_vld[k]);
    rd_issue = (state == S_UNLOAD) && !rd_done &&
               (({1'b0, fifo_cnt} + inflight) < (3'd2 + 3'(pop)));
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (iEN) state_next = S_LOAD;
      S_LOAD:   if (handshake_in && ld_cnt == CW'(N-1)) state_next = S_START;
      S_START:  state_next = S_WAIT;
      S_WAIT:   if (iCORE_RDY && rdy_low_seen) state_next = S_UNLOAD;
      S_UNLOAD: if (pop && oM_LAST) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      ld_cnt        <= '0;
      oCORE_DATA    <= '0;
      oCORE_ADDR_WR <= '0;
      oCORE_WE      <= '0;
    end else begin
      oCORE_WE <= '0;
      if (state == S_IDLE) ld_cnt <= '0;
      if (handshake_in) begin
        oCORE_DATA    <= iS_DATA;
        oCORE_ADDR_WR <= ld_cnt[CW-1:2];
        oCORE_WE      <= 4'b0001 << ld_cnt[1:0];
        ld_cnt        <= ld_cnt + CW'(1);
      end
    end
  end

  // A high RDY left over from the previous frame only counts after it has been seen low.
  always_ff @(posedge iCLK) begin
    if (iRESET)                           rdy_low_seen <= 1'b0;
    else if (state == S_START)            rdy_low_seen <= 1'b0;
    else if (state == S_WAIT && !iCORE_RDY) rdy_low_seen <= 1'b1;
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      rd_cnt   <= '0;
      rd_done  <= 1'b0;
      pipe_vld <= '0;
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_lane[k] <= '0;
        pipe_last[k] <= 1'b0;
      end
    end else begin
      if (state == S_WAIT) begin
        rd_cnt  <= '0;
        rd_done <= 1'b0;
      end else if (rd_issue) begin
        rd_cnt <= rd_cnt + CW'(1);
        if (rd_cnt == CW'(N-1)) rd_done <= 1'b1;
      end
      pipe_vld[0]  <= rd_issue;
      pipe_lane[0] <= rd_cnt[1:0];
      pipe_last[0] <= (rd_cnt == CW'(N-1));
      for (int k = 1; k < RD_LAT; k++) begin
        pipe_vld[k]  <= pipe_vld[k-1];
        pipe_lane[k] <= pipe_lane[k-1];
        pipe_last[k] <= pipe_last[k-1];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      for (int k = 0; k < 2; k++) begin
        fifo_data[k] <= '0;
        fifo_last[k] <= 1'b0;
      end
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= push_data;
        fifo_last[wr_ptr] <= pipe_last[RD_LAT-1];
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_fht_stream_ctrl.sv
// Directed bench for fht_stream_ctrl (A_BIT = 2, N = 16) with RD_LAT = 1 and RD_LAT = 2
// instances sharing stimulus; each gets its own behavioural core returning 100+bin.
module tb_fht_stream_ctrl;

  localparam int D = 16;
  localparam int A = 2;
  localparam int N = 16;

  logic iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  logic           iRESET, iEN, iS_VALID, iCORE_RDY, iM_READY;
  logic [D-2:0]   iS_DATA;

  logic           s_ready1, start1, m_valid1, m_last1, busy1;
  logic [D-2:0]   core_data1;
  logic [A-1:0]   addr_wr1;
  logic [3:0]     we1;
  logic [4*A-1:0] addr_rd1;
  logic [4*D-1:0] core_in1;
  logic [D-1:0]   m_data1;

  logic           s_ready2, start2, m_valid2, m_last2, busy2;
  logic [D-2:0]   core_data2;
  logic [A-1:0]   addr_wr2;
  logic [3:0]     we2;
  logic [4*A-1:0] addr_rd2;
  logic [4*D-1:0] core_in2, core_mid2;
  logic [D-1:0]   m_data2;

  fht_stream_ctrl #(.D_BIT(D), .A_BIT(A), .RD_LAT(1)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iS_DATA(iS_DATA), .iS_VALID(iS_VALID),
    .oS_READY(s_ready1), .oCORE_DATA(core_data1), .oCORE_ADDR_WR(addr_wr1), .oCORE_WE(we1),
    .oCORE_START(start1), .iCORE_RDY(iCORE_RDY), .oCORE_ADDR_RD(addr_rd1), .iCORE_DATA(core_in1),
    .oM_DATA(m_data1), .oM_VALID(m_valid1), .iM_READY(iM_READY), .oM_LAST(m_last1), .oBUSY(busy1)
  );

  fht_stream_ctrl #(.D_BIT(D), .A_BIT(A), .RD_LAT(2)) dut2 (
    .iCLK(iCLK), .iRESET(iRESET), .iEN(iEN), .iS_DATA(iS_DATA), .iS_VALID(iS_VALID),
    .oS_READY(s_ready2), .oCORE_DATA(core_data2), .oCORE_ADDR_WR(addr_wr2), .oCORE_WE(we2),
    .oCORE_START(start2), .iCORE_RDY(iCORE_RDY), .oCORE_ADDR_RD(addr_rd2), .iCORE_DATA(core_in2),
    .oM_DATA(m_data2), .oM_VALID(m_valid2), .iM_READY(iM_READY), .oM_LAST(m_last2), .oBUSY(busy2)
  );

  // Behavioural core RAM read port: bank b at address a holds 100 + (4*a + b).
  function automatic logic [4*D-1:0] coreModel(input logic [4*A-1:0] addr);
    logic [4*D-1:0] r;
    for (int b = 0; b < 4; b++) r[b*D +: D] = D'(100 + 4*int'(addr[b*A +: A]) + b);
    return r;
  endfunction

  always @(posedge iCLK) begin
    core_in1  <= coreModel(addr_rd1);
    core_mid2 <= coreModel(addr_rd2);
    core_in2  <= core_mid2;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  typedef struct {
    logic         valid;
    logic [D-2:0] data;
    logic [3:0]   exp_we;
    logic [A-1:0] exp_addr;
    logic [D-2:0] exp_data;
    logic         exp_ready;
    logic         exp_start;
  } vec_t;

  vec_t vecs[64];

  task automatic applyStimulus(input vec_t v);
    iS_VALID = v.valid;
    iS_DATA  = v.data;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("vec%0d we", idx), we1, v.exp_we);
    if (v.exp_we != 4'b0) begin
      check($sformatf("vec%0d addr_wr", idx), addr_wr1, v.exp_addr);
      check($sformatf("vec%0d core_data", idx), core_data1, v.exp_data);
    end
    check($sformatf("vec%0d s_ready", idx), s_ready1, v.exp_ready);
    check($sformatf("vec%0d start", idx), start1, v.exp_start);
  endtask

  // Output stream monitors: every handshake must carry the next bin in order.
  int   got1, got2, cur_run1, max_run1;
  logic hold1, hold2;
  logic [D-1:0] hold_data1, hold_data2;
  logic mon_on = 1'b0;

  always @(negedge iCLK) if (mon_on) begin
    if (m_valid1 && hold1) check("hold data1", m_data1, hold_data1);
    if (m_valid1 && iM_READY) begin
      check($sformatf("bin1 %0d data", got1), m_data1, 64'(100 + got1));
      check($sformatf("bin1 %0d last", got1), m_last1, got1 == N-1);
      got1++;
    end
    hold1      = m_valid1 && !iM_READY;
    hold_data1 = m_data1;
    cur_run1   = m_valid1 ? cur_run1 + 1 : 0;
    if (cur_run1 > max_run1) max_run1 = cur_run1;
  end

  always @(negedge iCLK) if (mon_on) begin
    if (m_valid2 && hold2) check("hold data2", m_data2, hold_data2);
    if (m_valid2 && iM_READY) begin
      check($sformatf("bin2 %0d data", got2), m_data2, 64'(100 + got2));
      check($sformatf("bin2 %0d last", got2), m_last2, got2 == N-1);
      got2++;
    end
    hold2      = m_valid2 && !iM_READY;
    hold_data2 = m_data2;
  end

  task automatic startFrame();
    iEN = 1'b1;
    tick();
    iEN = 1'b0;
    check("ready in LOAD", s_ready1, 1'b1);
    check("busy in LOAD", busy1, 1'b1);
  endtask

  task automatic runUnload(input bit full);
    bit done = 1'b0;
    got1 = 0; got2 = 0; cur_run1 = 0; max_run1 = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      iM_READY = full ? 1'b1 : ($urandom_range(0, 9) < 3);
      tick();
      if (got1 == N && got2 == N && !busy1 && !busy2) done = 1'b1;
    end
    iM_READY = 1'b0;
    check("unload finished in budget", done, 1'b1);
    check("bins received lat1", got1, N);
    check("bins received lat2", got2, N);
    if (full) check("consecutive valid lat1", max_run1, N);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int n = 0; n < N; n++) begin
      vecs[n]      = '{1'b1, (D-1)'(n), 4'(1 << (n % 4)), A'(n / 4), (D-1)'(n), n != N-1, n == N-1};
      vecs[48 + n] = '{1'b1, (D-1)'(16'h300 + n), 4'(1 << (n % 4)), A'(n / 4),
                       (D-1)'(16'h300 + n), n != N-1, n == N-1};
    end
    for (int j = 0; j < 2*N; j++) begin
      if (j % 2 == 0)
        vecs[16 + j] = '{1'b1, (D-1)'(16'h200 + j/2), 4'(1 << ((j/2) % 4)), A'(j / 8),
                         (D-1)'(16'h200 + j/2), j < 2*N-2, j == 2*N-2};
      else
        vecs[16 + j] = '{1'b0, (D-1)'(16'h7fff), 4'b0, '0, '0, j < 2*N-2, 1'b0};
    end

    iRESET = 1'b1; iEN = 1'b0; iS_VALID = 1'b0; iS_DATA = '0; iCORE_RDY = 1'b0; iM_READY = 1'b0;
    tick(); tick();
    check("reset busy", busy1, 1'b0);
    check("reset s_ready", s_ready1, 1'b0);
    check("reset we", we1, 4'b0);
    check("reset start", start1, 1'b0);
    check("reset addr_rd", addr_rd1, '0);
    check("reset m_valid", m_valid1, 1'b0);
    iRESET = 1'b0;
    mon_on = 1'b1;
    tick();
    check("idle without en", busy1, 1'b0);

    $display("[TB] frame 1: contiguous samples, full-rate unload");
    startFrame();
    for (int i = 0; i < N; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
      if (i == 5) check("sample5 bank1 we", we1, 4'b0010);
    end
    iS_VALID = 1'b0;
    tick();
    check("start single pulse", start1, 1'b0);
    check("we idle after load", we1, 4'b0);
    check("busy in WAIT", busy1, 1'b1);
    tick(); tick();
    iCORE_RDY = 1'b1;
    runUnload(1'b1);

    $display("[TB] frame 2: gapped samples, stale RDY, backpressured unload");
    startFrame();
    for (int i = 16; i < 48; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
    end
    iS_VALID = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("stale rdy no valid1 c%0d", c), m_valid1, 1'b0);
      check($sformatf("stale rdy no valid2 c%0d", c), m_valid2, 1'b0);
      check($sformatf("stale rdy busy c%0d", c), busy1, 1'b1);
    end
    iCORE_RDY = 1'b0;
    tick();
    iCORE_RDY = 1'b1;
    runUnload(1'b0);
    iCORE_RDY = 1'b0;

    $display("[TB] frame 3: reset after seventh sample");
    startFrame();
    for (int i = 48; i < 55; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
    end
    iRESET = 1'b1;
    tick();
    check("midreset busy", busy1, 1'b0);
    check("midreset s_ready", s_ready1, 1'b0);
    check("midreset we", we1, 4'b0);
    check("midreset addr_wr", addr_wr1, '0);
    check("midreset core_data", core_data1, '0);
    check("midreset start", start1, 1'b0);
    check("midreset addr_rd", addr_rd1, '0);
    check("midreset m_valid", m_valid1, 1'b0);
    check("midreset m_data", m_data1, '0);
    check("midreset m_last", m_last1, 1'b0);
    check("midreset busy2", busy2, 1'b0);
    iRESET = 1'b0;
    iS_VALID = 1'b0;
    tick();

    $display("[TB] frame 4: fresh frame after reset");
    startFrame();
    for (int i = 48; i < 64; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput(vecs[i], i);
    end
    iS_VALID = 1'b0;
    tick(); tick(); tick();
    iCORE_RDY = 1'b1;
    runUnload(1'b1);
    iCORE_RDY = 1'b0;
    tick();
    check("idle at end", busy1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
